// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: accepts a parallel word over valid/ready, shifts it
// MSB-first into an external scan chain and captures the displaced chain
// contents from scan_out as a parallel readback word.
module scan_chain_ctrl #(
    parameter int unsigned LEN   = 8,
    parameter int unsigned CNT_W = $clog2(LEN + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [LEN-1:0] cfg_data,
    input  logic           abort,
    output logic           scan_en,
    output logic           scan_in,
    input  logic           scan_out,
    output logic           busy,
    output logic           done,
    output logic           rb_valid,
    output logic [LEN-1:0] rb_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [LEN-1:0]   tx, tx_next;
    logic [LEN-1:0]   rb_next;
    logic             scan_en_next, scan_in_next, done_next, rb_valid_next;

    logic [LEN-1:0]   tx_shifted;
    logic [LEN-1:0]   rb_shifted;

    // Next tx word; its MSB is the bit to present on scan_in after this edge
    // (zero when LEN is 1, as the only bit has already been presented).
    assign tx_shifted = tx << 1;

    // Readback shift: the chain MSB enters at bit 0 so the first sample ends
    // up at the top once all LEN samples have been taken.
    if (LEN == 1) begin : g_rb_one
        assign rb_shifted = scan_out;
    end else begin : g_rb_many
        assign rb_shifted = {rb_data[LEN-2:0], scan_out};
    end

    assign cfg_ready = (state == IDLE) && !reset;
    assign busy      = (state == SHIFT);

    // State and registered outputs, asynchronously cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            tx       <= '0;
            rb_data  <= '0;
            scan_en  <= 1'b0;
            scan_in  <= 1'b0;
            done     <= 1'b0;
            rb_valid <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            tx       <= tx_next;
            rb_data  <= rb_next;
            scan_en  <= scan_en_next;
            scan_in  <= scan_in_next;
            done     <= done_next;
            rb_valid <= rb_valid_next;
        end
    end

    // Next-state and next-output decode for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_next    = state;
        count_next    = count;
        tx_next       = tx;
        rb_next       = rb_data;
        scan_en_next  = scan_en;
        scan_in_next  = scan_in;
        done_next     = 1'b0;
        rb_valid_next = rb_valid;

        case (state)
            IDLE: begin
                scan_en_next = 1'b0;
                scan_in_next = 1'b0;
                if (cfg_valid) begin
                    tx_next       = cfg_data;
                    count_next    = CNT_W'(LEN);
                    scan_en_next  = 1'b1;
                    scan_in_next  = cfg_data[LEN-1];
                    rb_valid_next = 1'b0;
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                // The chain shifts on this edge too, so capture and advance
                // even when aborting; the abort only stops further shifts.
                rb_next      = rb_shifted;
                tx_next      = tx_shifted;
                scan_in_next = tx_shifted[LEN-1];
                count_next   = count - CNT_W'(1);
                if (abort) begin
                    scan_en_next = 1'b0;
                    scan_in_next = 1'b0;
                    count_next   = '0;
                    state_next   = IDLE;
                end else if (count == CNT_W'(1)) begin
                    scan_en_next  = 1'b0;
                    scan_in_next  = 1'b0;
                    done_next     = 1'b1;
                    rb_valid_next = 1'b1;
                    state_next    = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Testbench for scan_chain_ctrl: LEN=8 instance against a transaction-level
// model plus a LEN=1 instance with directed literal checks.
module tb_scan_chain_ctrl;

    localparam int unsigned LEN = 8;

    logic           clk       = 1'b0;
    logic           reset     = 1'b1;
    logic           cfg_valid = 1'b0;
    logic [LEN-1:0] cfg_data  = '0;
    logic           abort     = 1'b0;
    logic           cfg_ready, scan_en, scan_in, busy, done, rb_valid;
    logic [LEN-1:0] rb_data;
    logic [LEN-1:0] chain     = '0;
    logic           scan_out;

    logic           v1 = 1'b0;
    logic [0:0]     d1 = '0;
    logic           rdy1, se1, si1, busy1, done1, rbv1;
    logic [0:0]     rb1;
    logic           chain1 = 1'b0;

    int checks = 0;
    int errors = 0;

    assign scan_out = chain[LEN-1];

    scan_chain_ctrl #(.LEN(LEN)) u_dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .abort(abort),
        .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
        .busy(busy), .done(done), .rb_valid(rb_valid), .rb_data(rb_data)
    );

    scan_chain_ctrl #(.LEN(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .cfg_valid(v1), .cfg_ready(rdy1), .cfg_data(d1),
        .abort(1'b0),
        .scan_en(se1), .scan_in(si1), .scan_out(chain1),
        .busy(busy1), .done(done1), .rb_valid(rbv1), .rb_data(rb1)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // The attached scan chains.
    always @(posedge clk) begin
        if (scan_en) chain <= {chain[LEN-2:0], scan_in};
        if (se1) chain1 <= si1;
    end

    // Event monitors: cycle count, accepts, shift edges, scan_in stream.
    int cyc = 0, acc_cnt = 0, acc_cyc = 0, acc_prev = 0, se_edges = 0;
    logic [LEN-1:0] sin_log = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cfg_valid && cfg_ready) begin
            acc_cnt  <= acc_cnt + 1;
            acc_prev <= acc_cyc;
            acc_cyc  <= cyc + 1;
        end
        if (scan_en) begin
            se_edges <= se_edges + 1;
            sin_log  <= {sin_log[LEN-2:0], scan_in};
        end
    end

    // Transaction model: phase 0 idle, 1 loading (m_pos bits already shifted), 2 done.
    int             m_phase = 0, m_pos = 0;
    logic [LEN-1:0] m_word = '0, m_snap = '0, m_rb = '0;
    logic           m_rbv = 1'b0, m_rb_chk = 1'b1;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_pos = 0; m_rb = '0; m_rbv = 1'b0; m_rb_chk = 1'b1;
        end else begin
            case (m_phase)
                0: if (cfg_valid) begin
                    m_phase = 1; m_pos = 0; m_word = cfg_data; m_snap = chain;
                    m_rbv = 1'b0; m_rb_chk = 1'b0;
                end
                1: if (abort) m_phase = 0;
                   else begin
                       m_pos++;
                       if (m_pos == LEN) begin
                           m_phase = 2; m_rb = m_snap; m_rbv = 1'b1; m_rb_chk = 1'b1;
                       end
                   end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the LEN=8 instance against the model.
    always @(negedge clk) begin
        chk("cfg_ready", cfg_ready, (m_phase == 0) && !reset);
        chk("busy", busy, m_phase == 1);
        chk("scan_en", scan_en, m_phase == 1);
        chk("scan_in", scan_in, (m_phase == 1) ? m_word[LEN-1-m_pos] : 1'b0);
        chk("done", done, m_phase == 2);
        chk("rb_valid", rb_valid, m_rbv);
        if (m_rb_chk) chk("rb_data", rb_data, m_rb);
        if (m_phase == 2) chk("chain_loaded", chain, m_word);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (acc_cnt < target && n < 60) begin step(); n++; end
        chk("accept_timeout", acc_cnt, target);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 60) begin step(); n++; end
        chk("done_timeout", done, 1);
    endtask

    task automatic load(input logic [LEN-1:0] w);
        int a0;
        a0 = acc_cnt;
        cfg_data = w; cfg_valid = 1'b1;
        wait_acc(a0 + 1);
        cfg_valid = 1'b0;
        wait_done();
    endtask

    int se0;

    initial begin
        repeat (3) step();
        chk("rst_ready", cfg_ready, 0);
        chk("rst_scan_en", scan_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rb_valid", rb_valid, 0);
        chk("rst_rb_data", rb_data, 0);
        reset = 1'b0;
        #1 chk("ready_after_rst", cfg_ready, 1);
        step();

        // Load 0xA5 into an all-zero chain.
        se0 = se_edges;
        load(8'hA5);
        chk("t1_chain", chain, 8'hA5);
        chk("t1_rb", rb_data, 8'h00);
        chk("t1_rbv", rb_valid, 1);
        chk("t1_scan_in_seq", sin_log, 8'hA5);
        chk("t1_shift_count", se_edges - se0, 8);
        chk("t1_latency", cyc - acc_cyc, 8);
        step();
        chk("t1_done_pulse", done, 0);
        chk("t1_ready_back", cfg_ready, 1);

        // Second load returns the first word.
        load(8'h3C);
        chk("t2_chain", chain, 8'h3C);
        chk("t2_rb", rb_data, 8'hA5);
        step();

        // cfg_valid held across two words.
        se0 = se_edges;
        cfg_data = 8'h11; cfg_valid = 1'b1;
        wait_acc(acc_cnt + 1);
        cfg_data = 8'h22;
        wait_acc(3 + 1);
        cfg_valid = 1'b0;
        chk("t3_accept_gap", acc_cyc - acc_prev, 10);
        wait_done();
        chk("t3_chain", chain, 8'h22);
        chk("t3_rb", rb_data, 8'h11);
        chk("t3_shift_count", se_edges - se0, 16);
        step();

        // Abort on the 3rd shift cycle of 0xFF.
        se0 = se_edges;
        cfg_data = 8'hFF; cfg_valid = 1'b1;
        wait_acc(5);
        cfg_valid = 1'b0;
        step(); step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_scan_en", scan_en, 0);
        chk("t4_shifts", se_edges - se0, 3);
        chk("t4_chain", chain, 8'h17);
        chk("t4_ready", cfg_ready, 1);
        chk("t4_rbv", rb_valid, 0);
        repeat (3) step();

        // Abort coinciding with the final shift: chain loaded, no done.
        se0 = se_edges;
        cfg_data = 8'hC3; cfg_valid = 1'b1;
        wait_acc(6);
        cfg_valid = 1'b0;
        repeat (7) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4b_done", done, 0);
        chk("t4b_rbv", rb_valid, 0);
        chk("t4b_chain", chain, 8'hC3);
        chk("t4b_shifts", se_edges - se0, 8);
        // abort while idle is ignored
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (2) step();

        // Reset during the 5th shift cycle.
        se0 = se_edges;
        cfg_data = 8'h5A; cfg_valid = 1'b1;
        wait_acc(7);
        cfg_valid = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        #1;
        chk("t5_scan_en", scan_en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_rbv", rb_valid, 0);
        chk("t5_rb", rb_data, 0);
        chk("t5_ready", cfg_ready, 0);
        chk("t5_shifts", se_edges - se0, 4);
        chk("t5_chain", chain, 8'h35);
        step();
        reset = 1'b0;
        step();
        load(8'h96);
        chk("t5_reload_chain", chain, 8'h96);
        chk("t5_reload_rb", rb_data, 8'h35);
        step();

        // LEN=1 instance.
        v1 = 1'b1; d1 = 1'b1;
        step();
        v1 = 1'b0;
        chk("l1_se", se1, 1);
        chk("l1_si", si1, 1);
        chk("l1_busy", busy1, 1);
        chk("l1_ready_low", rdy1, 0);
        step();
        chk("l1_done", done1, 1);
        chk("l1_se_off", se1, 0);
        chk("l1_chain", chain1, 1);
        chk("l1_rb", rb1, 0);
        chk("l1_rbv", rbv1, 1);
        step();
        chk("l1_done_off", done1, 0);
        chk("l1_ready", rdy1, 1);
        v1 = 1'b1; d1 = 1'b0;
        step();
        v1 = 1'b0;
        step();
        chk("l1_done2", done1, 1);
        chk("l1_chain2", chain1, 0);
        chk("l1_rb2", rb1, 1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
